// File: rtl/fp_sub_norm.sv
// Multi-cycle |A - B| for the 10-bit {E,M} float format (value = M * 2^E, no hidden bit).
// Aligns on the larger exponent, subtracts mantissas, then renormalizes one left shift per cycle.
module fp_sub_norm #(
    parameter int EW = 4,
    parameter int MW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [EW+MW-1:0] A,
    input  logic [EW+MW-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [EW+MW-1:0] Out,
    output logic             Sign,
    output logic             Zero
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_SUB   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [EW+MW-1:0]  a_q, a_d;
    logic [EW+MW-1:0]  b_q, b_d;
    logic [EW-1:0]     er_q, er_d;
    logic [MW-1:0]     big_q, big_d;
    logic [MW-1:0]     small_q, small_d;
    logic [MW-1:0]     diff_q, diff_d;
    logic              sgn_q, sgn_d;
    logic [EW+MW-1:0]  out_q, out_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic [EW-1:0]     ea_s, eb_s, gap_s, er_max_s, er_dec_s;
    logic [MW-1:0]     ma_s, mb_s, ma_al_s, mb_al_s;
    logic [MW-1:0]     diff_s, diff_sh_s;

    // Zero-filled right shift; a gap of MW or more pushes every mantissa bit out.
    function automatic logic [MW-1:0] shift_right(input logic [MW-1:0] m, input logic [EW-1:0] d);
        logic [MW-1:0] r;
        if (int'(d) >= MW) begin
            r = {MW{1'b0}};
        end else begin
            r = m >> d;
        end
        return r;
    endfunction

    // Alignment and arithmetic helpers derived from the captured operands and working registers.
    always_comb begin
        ea_s      = a_q[EW+MW-1:MW];
        eb_s      = b_q[EW+MW-1:MW];
        ma_s      = a_q[MW-1:0];
        mb_s      = b_q[MW-1:0];
        if (ea_s >= eb_s) begin
            er_max_s = ea_s;
            gap_s    = ea_s - eb_s;
            ma_al_s  = ma_s;
            mb_al_s  = shift_right(mb_s, gap_s);
        end else begin
            er_max_s = eb_s;
            gap_s    = eb_s - ea_s;
            ma_al_s  = shift_right(ma_s, gap_s);
            mb_al_s  = mb_s;
        end
        diff_s    = big_q - small_q;
        diff_sh_s = {diff_q[MW-2:0], 1'b0};
        er_dec_s  = er_q - {{(EW-1){1'b0}}, 1'b1};
    end

    // Next-state and datapath update; result registers load only on the transition into DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        er_d    = er_q;
        big_d   = big_q;
        small_d = small_q;
        diff_d  = diff_q;
        sgn_d   = sgn_q;
        out_d   = out_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = S_ALIGN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ALIGN: begin
                er_d = er_max_s;
                if (mb_al_s > ma_al_s) begin
                    big_d   = mb_al_s;
                    small_d = ma_al_s;
                    sgn_d   = 1'b1;
                end else begin
                    big_d   = ma_al_s;
                    small_d = mb_al_s;
                    sgn_d   = 1'b0;
                end
                state_d = S_SUB;
            end
            S_SUB: begin
                diff_d = diff_s;
                if (diff_s == {MW{1'b0}}) begin
                    out_d   = {(EW+MW){1'b0}};
                    sign_d  = 1'b0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (diff_s[MW-1] || (er_q == {EW{1'b0}})) begin
                    out_d   = {er_q, diff_s};
                    sign_d  = sgn_q;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                diff_d = diff_sh_s;
                er_d   = er_dec_s;
                if (diff_sh_s[MW-1] || (er_dec_s == {EW{1'b0}})) begin
                    out_d   = {er_dec_s, diff_sh_s};
                    sign_d  = sgn_q;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {(EW+MW){1'b0}};
            b_q     <= {(EW+MW){1'b0}};
            er_q    <= {EW{1'b0}};
            big_q   <= {MW{1'b0}};
            small_q <= {MW{1'b0}};
            diff_q  <= {MW{1'b0}};
            sgn_q   <= 1'b0;
            out_q   <= {(EW+MW){1'b0}};
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            er_q    <= er_d;
            big_q   <= big_d;
            small_q <= small_d;
            diff_q  <= diff_d;
            sgn_q   <= sgn_d;
            out_q   <= out_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign Out   = out_q;
    assign Sign  = sign_q;
    assign Zero  = zero_q;

endmodule

// File: tb/tb_fp_sub_norm.sv
// Scoreboard bench for fp_sub_norm: directed vectors plus random operands against an arithmetic model.
module tb_fp_sub_norm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] A, B;
    logic       ready, done;
    logic [9:0] Out;
    logic       Sign, Zero;

    typedef struct {
        logic [9:0] out;
        logic       sign;
        logic       zero;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fp_sub_norm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .done  (done),
        .Out   (Out),
        .Sign  (Sign),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value-level alignment by integer division, then shift up until the MSB is set or E hits 0.
    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b);
        exp_t e;
        int ea, eb, ma, mb, er, diff, n;
        ea = int'(a[9:6]); ma = int'(a[5:0]);
        eb = int'(b[9:6]); mb = int'(b[5:0]);
        if (ea >= eb) begin
            er = ea;
            mb = mb / (2 ** (ea - eb));
        end else begin
            er = eb;
            ma = ma / (2 ** (eb - ea));
        end
        e.sign = (mb > ma);
        diff   = (mb > ma) ? (mb - ma) : (ma - mb);
        n      = 0;
        if (diff == 0) begin
            e.out  = 10'd0;
            e.zero = 1'b1;
            e.sign = 1'b0;
        end else begin
            while (diff < 32 && er > 0) begin
                diff = diff * 2;
                er   = er - 1;
                n++;
            end
            e.out  = 10'((er * 64) + diff);
            e.zero = 1'b0;
        end
        e.lat = 3 + n;
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [9:0] a, input logic [9:0] b, input exp_t e, input bit push);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
        end else begin
            start = 1'b1;
            A     = a;
            B     = b;
            e.acc = cyc;
            if (push) q.push_back(e);
            @(posedge clk);
            #1;
            start = 1'b0;
            A     = 10'($urandom);
            B     = 10'($urandom);
        end
    endtask

    task automatic issue_model(input logic [9:0] a, input logic [9:0] b);
        issue(a, b, model(a, b), 1'b1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out", int'(Out), int'(e.out));
                chk("sign", int'(Sign), int'(e.sign));
                chk("zero", int'(Zero), int'(e.zero));
                chk("latency", cyc - e.acc, e.lat);
                chk("ready_in_done", int'(ready), 0);
            end
        end
    end

    initial begin
        exp_t  e;
        exp_t  dummy;
        int    w;
        logic [9:0] da [6]  = '{10'h168, 10'h0E1, 10'h090, 10'h2AA, 10'h270, 10'h3C0};
        logic [9:0] db [6]  = '{10'h148, 10'h0E0, 10'h114, 10'h2AA, 10'h07F, 10'h3FF};
        logic [9:0] dout[6] = '{10'h160, 10'h008, 10'h0E0, 10'h000, 10'h270, 10'h3FF};
        logic       dsg [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       dz  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         dlat[6] = '{3, 6, 4, 3, 3, 3};

        dummy = '{out: 10'd0, sign: 1'b0, zero: 1'b0, lat: 0, acc: 0};
        rst_n = 1'b0;
        start = 1'b0;
        A     = 10'd0;
        B     = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_out", int'(Out), 0);
        chk("rst_sign", int'(Sign), 0);
        chk("rst_zero", int'(Zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-derived results.
        for (int i = 0; i < 6; i++) begin
            e = '{out: dout[i], sign: dsg[i], zero: dz[i], lat: dlat[i], acc: 0};
            issue(da[i], db[i], e, 1'b1);
        end

        // Start pulses while busy must be ignored.
        issue_model(10'h168, 10'h148);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (!ready) begin
                start = 1'b1;
                A     = 10'($urandom);
                B     = 10'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        // Leave a non-zero result with Sign=1, then reset in the middle of NORM.
        issue_model(10'h090, 10'h114);
        issue(10'h0E1, 10'h0E0, dummy, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_out", int'(Out), 0);
        chk("abort_sign", int'(Sign), 0);
        chk("abort_zero", int'(Zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random operands, issued as soon as ready allows.
        for (int i = 0; i < 150; i++) begin
            issue_model(10'($urandom), 10'($urandom));
        end
        for (int i = 0; i < 20; i++) begin
            issue_model(10'($urandom), 10'($urandom) & 10'h3C0 | 10'($urandom_range(0, 63)));
        end

        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_sub_norm.md
Name: fp_sub_norm

Overview:
- Multi-cycle subtractor for the team's 10-bit floating-point format: bits [9:6] are an unsigned exponent E, bits [5:0] an unsigned mantissa M, value = M * 2^E, no hidden bit.
- Computes |A - B| with a separate sign flag. Aligns by right-shifting the smaller-exponent operand, subtracts magnitudes, then renormalizes by left shift, one bit per cycle.
- This is the left-shift / decrement counterpart of the adder's right-shift / increment path. It sits beside the 10-bit FP adder in the arithmetic datapath.
- A start/ready/done handshake sequences it.

Parameters:
- EW, 4, exponent width.
- MW, 6, mantissa width. Total word is EW+MW = 10.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while ready=1.
- A  in  10  minuend {E,M}; captured when start is accepted.
- B  in  10  subtrahend {E,M}; captured when start is accepted.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; Out, Sign and Zero are valid from this cycle.
- Out  out  10  normalized magnitude {Er,Mr}.
- Sign  out  1  1 when B > A in magnitude.
- Zero  out  1  1 when the result is exactly zero.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: IDLE, ready=1, done=0, Out=0, Sign=0, Zero=0, all internal registers 0.
- Reset mid-operation: aborts immediately, returns to IDLE, clears outputs, no done pulse.
- FSM states: IDLE, ALIGN, SUB, NORM, DONE.
- IDLE:
  - start=1 latches A and B, goes to ALIGN.
  - start=0 stays in IDLE.
- ALIGN (1 cycle):
  - Er = max(EA,EB), d = |EA-EB|.
  - Right-shift the smaller-exponent operand's mantissa by d, with zero fill. If d >= MW, the shifted mantissa is 0; truncated bits are discarded.
  - If EA = EB, no shift.
  - Compare the aligned mantissas. Sign = 1 iff aligned MB > aligned MA; equal gives Sign = 0.
- SUB (1 cycle):
  - diff = larger aligned mantissa - smaller, MW bits, never borrows.
  - diff = 0: Out=0, Zero=1, Sign=0, go to DONE.
  - diff[MW-1] = 1 or Er = 0: go to DONE.
  - Otherwise go to NORM.
- NORM (one cycle per shift):
  - Each cycle: diff <<= 1 and Er -= 1.
  - Exit to DONE when the new diff[MW-1] = 1 or the new Er = 0.
  - Er never underflows; at most MW-1 = 5 shifts.
- DONE (1 cycle): done=1, then IDLE.
- Output registers: Out={Er,diff}, Sign and Zero load on entry to DONE. They hold until the next DONE or reset.
- Latency: start sampled high in cycle T gives done=1 in cycle T+3+n, where n = number of NORM shifts (0..5).
- Throughput: ready returns one cycle after done. start is ignored while ready=0; no queuing.
- Changes on A/B after acceptance have no effect.

Test Plan:
- Aligned, no shift: A=0x168, B=0x148 (E5 M40 - E5 M8) -> Out=0x160, Sign=0, Zero=0, done at T+3.
- Normalize clamped by exponent: A=0x0E1, B=0x0E0 (E3 M33 - E3 M32) -> diff=1, 3 shifts, stops at Er=0 -> Out=0x008, Sign=0, done at T+6.
- Swap/sign: A=0x090 (E2 M16), B=0x114 (E4 M20) -> A mantissa aligned to 4, diff=16, 1 shift -> Out=0x0E0, Sign=1, done at T+4.
- Exact cancel: A=B=0x2AA -> Out=0x000, Zero=1, Sign=0, done at T+3.
- Large exponent gap: A=0x270 (E9 M48), B=0x07F (E1 M63, d=8) -> B mantissa becomes 0 -> Out=0x270, Sign=0, done at T+3.
- Control: start pulses while busy are ignored (single done, result of first operands); rst_n low during NORM -> IDLE, ready=1, Out/Sign/Zero=0, no done pulse; back-to-back ops after ready are accepted correctly.
